// File: rtl/ltsm_sb_handshake_engine.sv
// Sideband REQ/RESP handshake engine: local module FSM and remote partner FSM share one TX port,
// with REQ resend on missing RESP, an overall timeout and re-answering of duplicate partner REQs.
module ltsm_sb_handshake_engine #(
  parameter int unsigned SB_MSG_WIDTH = 4,
  parameter logic [SB_MSG_WIDTH-1:0] REQ_CODE = SB_MSG_WIDTH'(1),
  parameter logic [SB_MSG_WIDTH-1:0] RESP_CODE = SB_MSG_WIDTH'(2),
  parameter int unsigned RESEND_CYCLES = 64,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_hs_en,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_rx_sb_msg,
  input  logic                    i_falling_edge_busy,
  output logic [SB_MSG_WIDTH-1:0] o_tx_sb_msg,
  output logic                    o_tx_msg_valid,
  output logic                    o_hs_done,
  output logic                    o_hs_timeout,
  output logic [RETRY_W-1:0]      o_retry_cnt
);

  localparam int unsigned RS_W = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES + 1) : 1;
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESEND_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {MIdle, MReqPend, MWaitResp, MDone} m_state_e;
  typedef enum logic [1:0] {PIdle, PRespPend, PRespSent, PDone} p_state_e;
  typedef enum logic {TIdle, TBusy} t_state_e;

  m_state_e m_q, m_d;
  p_state_e p_q, p_d;
  t_state_e t_q, t_d;
  logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [SB_MSG_WIDTH-1:0] tx_msg_q, tx_msg_d;
  logic en_q, p_seen_q, p_seen_d, done_q, done_d, timeout_q, timeout_d, tx_valid_q, tx_valid_d;
  logic rx_req, rx_resp, rise, p_done_evt, timeout_set, can_grant;
  logic resp_want, req_want, grant_resp, grant_req;

  assign rx_req     = i_rx_msg_valid && (i_rx_sb_msg == REQ_CODE);
  assign rx_resp    = i_rx_msg_valid && (i_rx_sb_msg == RESP_CODE);
  assign rise       = i_hs_en && !en_q;
  assign p_done_evt = (p_q == PRespSent) && (t_q == TBusy) && i_falling_edge_busy;

  // Done is derived from pre-grant state so the timeout gate below never depends on a grant.
  assign done_d = ((m_q == MDone) || ((m_q == MWaitResp) && rx_resp)) &&
                  (p_seen_q || p_done_evt);
  assign timeout_set = !done_q && !timeout_q && !done_d && (to_cnt_q == TO_LAST);

  // A live RX REQ counts as a pending RESP so it is granted in the same cycle it arrives.
  assign can_grant  = (t_q == TIdle) && !timeout_q && !timeout_set;
  assign resp_want  = (p_q == PRespPend) || (rx_req && ((p_q == PIdle) || (p_q == PDone)));
  assign req_want   = (m_q == MReqPend);
  assign grant_resp = can_grant && resp_want;
  assign grant_req  = can_grant && req_want && !resp_want;

  always_comb begin
    m_d        = m_q;
    p_d        = p_q;
    t_d        = t_q;
    rs_cnt_d   = rs_cnt_q;
    retry_d    = retry_q;
    p_seen_d   = p_seen_q;
    tx_msg_d   = tx_msg_q;
    tx_valid_d = 1'b0;
    to_cnt_d   = to_cnt_q;
    timeout_d  = timeout_q | timeout_set;

    unique case (m_q)
      MIdle:     if (rise) m_d = MReqPend;
      MReqPend: begin
        if (grant_req) begin
          m_d      = MWaitResp;
          rs_cnt_d = '0;
        end
      end
      MWaitResp: begin
        if (rx_resp) begin
          m_d = MDone;
        end else if (rs_cnt_q == RS_LAST) begin
          if (retry_q < RETRY_MAX) begin
            m_d     = MReqPend;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          rs_cnt_d = rs_cnt_q + RS_W'(1);
        end
      end
      default:   m_d = MDone;
    endcase

    unique case (p_q)
      PIdle, PDone: if (rx_req) p_d = grant_resp ? PRespSent : PRespPend;
      PRespPend:    if (grant_resp) p_d = PRespSent;
      default: begin
        if (p_done_evt) begin
          p_d      = PDone;
          p_seen_d = 1'b1;
        end
      end
    endcase

    unique case (t_q)
      TIdle: begin
        if (grant_resp || grant_req) begin
          t_d        = TBusy;
          tx_valid_d = 1'b1;
          tx_msg_d   = grant_resp ? RESP_CODE : REQ_CODE;
        end
      end
      default: if (i_falling_edge_busy) t_d = TIdle;
    endcase

    if (!done_q && !timeout_q) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  // Dropping enable clears everything exactly like reset.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_hs_en) begin
      en_q       <= 1'b0;
      m_q        <= MIdle;
      p_q        <= PIdle;
      t_q        <= TIdle;
      rs_cnt_q   <= '0;
      retry_q    <= '0;
      to_cnt_q   <= '0;
      p_seen_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      tx_msg_q   <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      en_q       <= 1'b1;
      m_q        <= m_d;
      p_q        <= p_d;
      t_q        <= t_d;
      rs_cnt_q   <= rs_cnt_d;
      retry_q    <= retry_d;
      to_cnt_q   <= to_cnt_d;
      p_seen_q   <= p_seen_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      tx_msg_q   <= tx_msg_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign o_tx_sb_msg    = tx_msg_q;
  assign o_tx_msg_valid = tx_valid_q;
  assign o_hs_done      = done_q;
  assign o_hs_timeout   = timeout_q;
  assign o_retry_cnt    = retry_q;

endmodule

// File: tb/tb_ltsm_sb_handshake_engine.sv
// Directed bench: instance a uses default timing, instance b short resend/timeout; shared inputs.
module tb_ltsm_sb_handshake_engine;
  localparam logic [3:0] REQ  = 4'h1;
  localparam logic [3:0] RESP = 4'h2;

  logic clk = 1'b0;
  logic rst, en, rx_valid, busy;
  logic [3:0] rx_msg;
  logic [3:0] a_msg, b_msg;
  logic a_valid, b_valid, a_done, b_done, a_to, b_to;
  logic [1:0] a_retry, b_retry;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ltsm_sb_handshake_engine #(
    .SB_MSG_WIDTH(4), .REQ_CODE(REQ), .RESP_CODE(RESP),
    .RESEND_CYCLES(64), .MAX_RETRY(3), .TIMEOUT_CYCLES(1024)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_hs_en(en), .i_rx_msg_valid(rx_valid), .i_rx_sb_msg(rx_msg),
    .i_falling_edge_busy(busy), .o_tx_sb_msg(a_msg), .o_tx_msg_valid(a_valid),
    .o_hs_done(a_done), .o_hs_timeout(a_to), .o_retry_cnt(a_retry)
  );

  ltsm_sb_handshake_engine #(
    .SB_MSG_WIDTH(4), .REQ_CODE(REQ), .RESP_CODE(RESP),
    .RESEND_CYCLES(8), .MAX_RETRY(3), .TIMEOUT_CYCLES(50)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_hs_en(en), .i_rx_msg_valid(rx_valid), .i_rx_sb_msg(rx_msg),
    .i_falling_edge_busy(busy), .o_tx_sb_msg(b_msg), .o_tx_msg_valid(b_valid),
    .o_hs_done(b_done), .o_hs_timeout(b_to), .o_retry_cnt(b_retry)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 0 of a fresh handshake, with enable just raised.
  task automatic restart();
    en = 1'b0; rx_valid = 1'b0; rx_msg = '0; busy = 1'b0; rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic rx(input logic [3:0] m);
    rx_valid = 1'b1;
    rx_msg   = m;
  endtask

  initial begin
    en = 1'b0; rx_valid = 1'b0; rx_msg = '0; busy = 1'b0; rst = 1'b1;
    tick();
    check_eq("reset a_msg", a_msg, 0);
    check_eq("reset a_valid", a_valid, 0);
    check_eq("reset a_done", a_done, 0);
    check_eq("reset a_timeout", a_to, 0);
    check_eq("reset a_retry", a_retry, 0);
    check_eq("reset b_msg", b_msg, 0);

    // Basic handshake, ignored RESP/unknown codes, then a duplicate REQ after done.
    restart();
    for (int c = 0; c <= 20; c++) begin
      check_eq($sformatf("basic valid c%0d", c), a_valid, (c == 2 || c == 7 || c == 15));
      check_eq($sformatf("basic done c%0d", c), a_done, (c >= 11));
      if (c == 2 || c == 3) check_eq($sformatf("basic msg c%0d", c), a_msg, REQ);
      if (c == 7 || c == 8 || c == 15) check_eq($sformatf("basic msg c%0d", c), a_msg, RESP);
      if (c == 20) begin
        check_eq("basic retry", a_retry, 0);
        check_eq("basic timeout", a_to, 0);
      end
      rx_valid = 1'b0; busy = 1'b0;
      if (c == 5 || c == 9 || c == 17) busy = 1'b1;
      if (c == 6 || c == 14) rx(REQ);
      if (c == 1 || c == 10) rx(RESP);
      if (c == 12) rx(4'hF);
      tick();
    end

    // RX REQ collides with the module entering REQ_PEND: RESP goes out first.
    restart();
    for (int c = 0; c <= 12; c++) begin
      check_eq($sformatf("coll valid c%0d", c), a_valid, (c == 2 || c == 6));
      check_eq($sformatf("coll done c%0d", c), a_done, (c >= 10));
      if (c == 2) check_eq("coll first msg", a_msg, RESP);
      if (c == 6) check_eq("coll second msg", a_msg, REQ);
      rx_valid = 1'b0; busy = 1'b0;
      if (c == 4 || c == 8) busy = 1'b1;
      if (c == 1) rx(REQ);
      if (c == 9) rx(RESP);
      tick();
    end

    // Silent partner on b: three resends, then timeout at cycle 50 blocks new grants.
    restart();
    for (int c = 0; c <= 60; c++) begin
      check_eq($sformatf("resend valid c%0d", c), b_valid,
               (c == 2 || c == 11 || c == 20 || c == 29));
      check_eq($sformatf("resend retry c%0d", c), b_retry,
               (c < 10) ? 0 : (c < 19) ? 1 : (c < 28) ? 2 : 3);
      check_eq($sformatf("timeout c%0d", c), b_to, (c >= 50));
      if (c == 29) check_eq("resend msg", b_msg, REQ);
      if (c == 60) check_eq("timeout done", b_done, 0);
      rx_valid = 1'b0; busy = 1'b0;
      if (c == 4 || c == 13 || c == 22 || c == 31) busy = 1'b1;
      if (c == 52) rx(REQ);
      tick();
    end

    // Enable dropped while TX busy, then re-enabled.
    restart();
    for (int c = 0; c <= 8; c++) begin
      check_eq($sformatf("abort valid c%0d", c), a_valid, (c == 2 || c == 6));
      if (c == 4) begin
        check_eq("abort msg", a_msg, 0);
        check_eq("abort b_msg", b_msg, 0);
        check_eq("abort done", a_done, 0);
      end
      if (c == 6) check_eq("abort restart msg", a_msg, REQ);
      en = (c != 3);
      tick();
    end

    // Reset pulse mid-handshake (b has already resent once), then clean restart.
    restart();
    for (int c = 0; c <= 18; c++) begin
      check_eq($sformatf("rst a valid c%0d", c), a_valid, (c == 2 || c == 16));
      check_eq($sformatf("rst b valid c%0d", c), b_valid, (c == 2 || c == 11 || c == 16));
      if (c == 12) check_eq("rst b retry before", b_retry, 1);
      if (c == 13) begin
        check_eq("rst b retry after", b_retry, 0);
        check_eq("rst a msg", a_msg, 0);
        check_eq("rst b msg", b_msg, 0);
      end
      rx_valid = 1'b0; busy = 1'b0;
      if (c == 4) busy = 1'b1;
      rst = (c == 12);
      en  = (c != 13);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
